// File: rtl/timestep_sequencer_if.sv
// ============================================================================
//  Module      : timestep_sequencer_if
//  Description : Host handshake and datapath control bundle of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface timestep_sequencer_if #(
    parameter int TS_W       = 8,
    parameter int W_ADDR_W   = 11,
    parameter int GRP_W      = 6,
    parameter int MEM_ADDR_W = 9
);
    logic                  start;
    logic [TS_W-1:0]       num_ts;
    logic                  stall;
    logic                  busy;
    logic                  done;
    logic [TS_W-1:0]       ts_count;
    logic [W_ADDR_W-1:0]   w_read_sram_addr;
    logic                  cntrl_ac_reset;
    logic                  cntrl_ac_oen;
    logic [GRP_W-1:0]      cntrl_u_in_select;
    logic [GRP_W-1:0]      cntrl_u_out_select;
    logic [MEM_ADDR_W-1:0] cntrl_potential_read_addr;
    logic [MEM_ADDR_W-1:0] cntrl_beta_read_addr;
    logic [MEM_ADDR_W-1:0] cntrl_potential_write_addr;
    logic                  cntrl_potential_write_we;
    logic [MEM_ADDR_W-1:0] cntrl_spk_write_addr;
    logic                  cntrl_spk_write_we;

    modport master (
        input  start, num_ts, stall,
        output busy, done, ts_count, w_read_sram_addr,
               cntrl_ac_reset, cntrl_ac_oen,
               cntrl_u_in_select, cntrl_u_out_select,
               cntrl_potential_read_addr, cntrl_beta_read_addr,
               cntrl_potential_write_addr, cntrl_potential_write_we,
               cntrl_spk_write_addr, cntrl_spk_write_we
    );

    modport slave (
        output start, num_ts, stall,
        input  busy, done, ts_count, w_read_sram_addr,
               cntrl_ac_reset, cntrl_ac_oen,
               cntrl_u_in_select, cntrl_u_out_select,
               cntrl_potential_read_addr, cntrl_beta_read_addr,
               cntrl_potential_write_addr, cntrl_potential_write_we,
               cntrl_spk_write_addr, cntrl_spk_write_we
    );
endinterface

`default_nettype wire

// File: rtl/timestep_sequencer.sv
// ============================================================================
//  Module      : timestep_sequencer
//  Description : Runs num_ts timesteps of clear / accumulate / group sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timestep_sequencer #(
    parameter int N_W_ROWS   = 2048,
    parameter int W_ADDR_W   = 11,
    parameter int N_GROUPS   = 64,
    parameter int GRP_W      = 6,
    parameter int MEM_ADDR_W = 9,
    parameter int TS_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    timestep_sequencer_if.master bus
);
    localparam logic [W_ADDR_W-1:0] C_LAST_ROW = W_ADDR_W'(N_W_ROWS - 1);
    localparam logic [GRP_W-1:0]    C_LAST_GRP = GRP_W'(N_GROUPS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACCUM  = 3'd2,
        S_LOAD   = 3'd3,
        S_UPDATE = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [W_ADDR_W-1:0]   r_row,      w_row_nxt;
    logic [GRP_W-1:0]      r_grp,      w_grp_nxt;
    logic [TS_W-1:0]       r_ts_count, w_ts_count_nxt;
    logic [TS_W-1:0]       r_num_ts,   w_num_ts_nxt;
    // Last values driven by each phase, presented while the phase is inactive
    logic [W_ADDR_W-1:0]   r_waddr,    w_waddr_nxt;
    logic [MEM_ADDR_W-1:0] r_rd_addr,  w_rd_addr_nxt;
    logic [GRP_W-1:0]      r_in_sel,   w_in_sel_nxt;
    logic [GRP_W-1:0]      r_out_sel,  w_out_sel_nxt;
    logic [MEM_ADDR_W-1:0] r_wr_addr,  w_wr_addr_nxt;

    logic                  w_ac_reset;
    logic                  w_ac_oen;
    logic                  w_we;
    logic                  w_done;
    logic [MEM_ADDR_W-1:0] w_grp_addr;
    logic [TS_W-1:0]       w_ts_inc;

    assign w_grp_addr = MEM_ADDR_W'(r_grp);
    assign w_ts_inc   = r_ts_count + TS_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_grp      <= '0;
            r_ts_count <= '0;
            r_num_ts   <= '0;
            r_waddr    <= '0;
            r_rd_addr  <= '0;
            r_in_sel   <= '0;
            r_out_sel  <= '0;
            r_wr_addr  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_grp      <= w_grp_nxt;
            r_ts_count <= w_ts_count_nxt;
            r_num_ts   <= w_num_ts_nxt;
            r_waddr    <= w_waddr_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_in_sel   <= w_in_sel_nxt;
            r_out_sel  <= w_out_sel_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_grp_nxt      = r_grp;
        w_ts_count_nxt = r_ts_count;
        w_num_ts_nxt   = r_num_ts;
        w_waddr_nxt    = r_waddr;
        w_rd_addr_nxt  = r_rd_addr;
        w_in_sel_nxt   = r_in_sel;
        w_out_sel_nxt  = r_out_sel;
        w_wr_addr_nxt  = r_wr_addr;
        w_ac_reset     = 1'b0;
        w_ac_oen       = 1'b0;
        w_we           = 1'b0;
        w_done         = 1'b0;

        // A stalled cycle changes nothing, so it is replayed intact afterwards
        if (!bus.stall) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_num_ts_nxt   = bus.num_ts;
                        w_ts_count_nxt = '0;
                        w_state_nxt    = (bus.num_ts == '0) ? S_DONE : S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    w_ac_reset  = 1'b1;
                    w_row_nxt   = '0;
                    w_state_nxt = S_ACCUM;
                end
                S_ACCUM: begin
                    w_ac_oen    = 1'b1;
                    w_waddr_nxt = r_row;
                    if (r_row == C_LAST_ROW) begin
                        w_row_nxt   = '0;
                        w_grp_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_row_nxt = r_row + W_ADDR_W'(1);
                    end
                end
                S_LOAD: begin
                    w_rd_addr_nxt = w_grp_addr;
                    w_state_nxt   = S_UPDATE;
                end
                S_UPDATE: begin
                    w_in_sel_nxt = r_grp;
                    w_state_nxt  = S_WRITE;
                end
                S_WRITE: begin
                    w_we          = 1'b1;
                    w_out_sel_nxt = r_grp;
                    w_wr_addr_nxt = w_grp_addr;
                    if (r_grp != C_LAST_GRP) begin
                        w_grp_nxt   = r_grp + GRP_W'(1);
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_ts_count_nxt = w_ts_inc;
                        w_state_nxt    = (w_ts_inc == r_num_ts) ? S_DONE : S_CLEAR;
                    end
                end
                S_DONE: begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign bus.busy                       = (r_state != S_IDLE);
    assign bus.done                       = w_done;
    assign bus.ts_count                   = r_ts_count;
    assign bus.cntrl_ac_reset             = w_ac_reset;
    assign bus.cntrl_ac_oen               = w_ac_oen;
    assign bus.cntrl_potential_write_we   = w_we;
    assign bus.cntrl_spk_write_we         = w_we;
    assign bus.w_read_sram_addr           = (r_state == S_ACCUM)  ? r_row      : r_waddr;
    assign bus.cntrl_potential_read_addr  = (r_state == S_LOAD)   ? w_grp_addr : r_rd_addr;
    assign bus.cntrl_beta_read_addr       = (r_state == S_LOAD)   ? w_grp_addr : r_rd_addr;
    assign bus.cntrl_u_in_select          = (r_state == S_UPDATE) ? r_grp      : r_in_sel;
    assign bus.cntrl_u_out_select         = (r_state == S_WRITE)  ? r_grp      : r_out_sel;
    assign bus.cntrl_potential_write_addr = (r_state == S_WRITE)  ? w_grp_addr : r_wr_addr;
    assign bus.cntrl_spk_write_addr       = (r_state == S_WRITE)  ? w_grp_addr : r_wr_addr;

endmodule

`default_nettype wire

// File: tb/tb_timestep_sequencer.sv
// ============================================================================
//  Module      : tb_timestep_sequencer
//  Description : Self-checking bench comparing every cycle to a phase schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timestep_sequencer;
    localparam int C_ROWS   = 2048;
    localparam int C_GRPS   = 64;
    localparam int C_TS_LAT = 1 + C_ROWS + 3 * C_GRPS;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       ac_reset;
        logic       ac_oen;
        logic       pot_we;
        logic       spk_we;
        logic [10:0] waddr;
        logic [8:0]  rd;
        logic [8:0]  beta;
        logic [5:0]  in_sel;
        logic [5:0]  out_sel;
        logic [8:0]  pwa;
        logic [8:0]  swa;
        logic [7:0]  ts;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    rec_t q[$];
    int   m_waddr, m_rd, m_in, m_out, m_wr;

    always #5 clk = ~clk;

    timestep_sequencer_if bus ();

    timestep_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic rec_t observe();
        rec_t o;
        o.busy     = bus.busy;
        o.done     = bus.done;
        o.ac_reset = bus.cntrl_ac_reset;
        o.ac_oen   = bus.cntrl_ac_oen;
        o.pot_we   = bus.cntrl_potential_write_we;
        o.spk_we   = bus.cntrl_spk_write_we;
        o.waddr    = bus.w_read_sram_addr;
        o.rd       = bus.cntrl_potential_read_addr;
        o.beta     = bus.cntrl_beta_read_addr;
        o.in_sel   = bus.cntrl_u_in_select;
        o.out_sel  = bus.cntrl_u_out_select;
        o.pwa      = bus.cntrl_potential_write_addr;
        o.swa      = bus.cntrl_spk_write_addr;
        o.ts       = bus.ts_count;
        return o;
    endfunction

    function automatic rec_t base(input logic busy, input int ts);
        rec_t e;
        e         = '0;
        e.busy    = busy;
        e.waddr   = 11'(m_waddr);
        e.rd      = 9'(m_rd);
        e.beta    = 9'(m_rd);
        e.in_sel  = 6'(m_in);
        e.out_sel = 6'(m_out);
        e.pwa     = 9'(m_wr);
        e.swa     = 9'(m_wr);
        e.ts      = 8'(ts);
        return e;
    endfunction

    function automatic void clear_model();
        m_waddr = 0; m_rd = 0; m_in = 0; m_out = 0; m_wr = 0;
    endfunction

    // Expected unstalled cycle sequence of one run, ending with one idle cycle
    function automatic void build_run(input int n);
        rec_t e;
        q.delete();
        for (int t = 0; t < n; t++) begin
            e = base(1'b1, t); e.ac_reset = 1'b1; q.push_back(e);
            for (int r = 0; r < C_ROWS; r++) begin
                m_waddr = r;
                e = base(1'b1, t); e.ac_oen = 1'b1; q.push_back(e);
            end
            for (int g = 0; g < C_GRPS; g++) begin
                m_rd = g;  e = base(1'b1, t); q.push_back(e);
                m_in = g;  e = base(1'b1, t); q.push_back(e);
                m_out = g; m_wr = g;
                e = base(1'b1, t); e.pot_we = 1'b1; e.spk_we = 1'b1; q.push_back(e);
            end
        end
        e = base(1'b1, n); e.done = 1'b1; q.push_back(e);
        e = base(1'b0, n); q.push_back(e);
    endfunction

    task automatic run_checked(input string name, input int n, input int stall_pct,
                               input int dir_idx, input int dir_len, input bit noise,
                               input int abort_idx);
        rec_t exp, obs;
        int idx = 0, cyc = 0, stalls = 0, dir_left = dir_len;
        int cnt_clr = 0, cnt_oen = 0, cnt_we = 0, done_cyc = -1, run_err = 0, limit;
        bit s;
        build_run(n);
        limit = 2 * q.size() + 100;
        @(negedge clk);
        bus.num_ts = 8'(n);
        bus.start  = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (idx < q.size() && cyc < limit && run_err < 10) begin
            s = 1'b0;
            if (idx == dir_idx && dir_left > 0) begin
                s = 1'b1;
                dir_left--;
            end else if (stall_pct > 0 && q[idx].busy && $urandom_range(99) < stall_pct) begin
                s = 1'b1;
            end
            bus.stall = s;
            if (noise && q[idx].busy && !q[idx].done) begin
                bus.start  = 1'($urandom_range(1));
                bus.num_ts = 8'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            #1;
            exp = q[idx];
            if (s) begin
                exp.ac_reset = 1'b0; exp.ac_oen = 1'b0;
                exp.pot_we   = 1'b0; exp.spk_we = 1'b0; exp.done = 1'b0;
            end
            obs = observe();
            checks++;
            if (obs !== exp) begin
                errors++; run_err++;
                $display("FAIL %s cycle %0d step %0d stall=%0b: got %h expected %h",
                         name, cyc, idx, s, obs, exp);
            end
            if (s) begin
                stalls++;
            end else begin
                if (obs.ac_reset) cnt_clr++;
                if (obs.ac_oen) cnt_oen++;
                if (obs.pot_we && obs.spk_we) cnt_we++;
                if (obs.done) done_cyc = cyc + 1;
                idx++;
            end
            cyc++;
            if (abort_idx >= 0 && idx > abort_idx) break;
            @(posedge clk); #1;
        end
        bus.stall = 1'b0;
        bus.start = 1'b0;
        if (run_err >= 10) begin
            reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
            clear_model();
            return;
        end
        if (abort_idx >= 0) return;
        checks++;
        if (idx < q.size()) begin
            errors++;
            $display("FAIL %s_timeout: reached step %0d of %0d", name, idx, q.size());
            return;
        end
        checks++;
        if (cnt_clr !== n) begin
            errors++; $display("FAIL %s_clear_pulses: got %0d expected %0d", name, cnt_clr, n);
        end
        checks++;
        if (cnt_oen !== n * C_ROWS) begin
            errors++; $display("FAIL %s_oen_cycles: got %0d expected %0d", name, cnt_oen, n * C_ROWS);
        end
        checks++;
        if (cnt_we !== n * C_GRPS) begin
            errors++; $display("FAIL %s_write_pairs: got %0d expected %0d", name, cnt_we, n * C_GRPS);
        end
        checks++;
        if (done_cyc !== n * C_TS_LAT + 1 + stalls) begin
            errors++;
            $display("FAIL %s_done_latency: got %0d expected %0d", name, done_cyc,
                     n * C_TS_LAT + 1 + stalls);
        end
        checks++;
        if (bus.ts_count !== 8'(n)) begin
            errors++; $display("FAIL %s_ts_count: got %0d expected %0d", name, bus.ts_count, n);
        end
    endtask

    task automatic test_reset();
        rec_t obs;
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.num_ts = 8'd5;
        bus.stall  = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        obs = observe();
        checks++;
        if (obs !== rec_t'('0)) begin
            errors++; $display("FAIL reset_with_start: got %h expected 0", obs);
        end
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        obs = observe();
        checks++;
        if (obs !== rec_t'('0)) begin
            errors++; $display("FAIL reset_idle: got %h expected 0", obs);
        end
    endtask

    task automatic test_single();      run_checked("single", 1, 0, -1, 0, 1'b0, -1); endtask
    task automatic test_zero();        run_checked("zero_ts", 0, 0, -1, 0, 1'b0, -1); endtask
    task automatic test_multi();       run_checked("multi", 3, 0, -1, 0, 1'b0, -1); endtask
    task automatic test_stall();       run_checked("stall_r100", 1, 0, 101, 5, 1'b0, -1); endtask
    task automatic test_back_to_back();
        run_checked("start_ignored", 2, 0, -1, 0, 1'b1, -1);
    endtask
    task automatic test_random();
        run_checked("random", int'($urandom_range(1, 2)), 10, -1, 0, 1'b1, -1);
    endtask

    task automatic test_reset_midrun();
        rec_t obs;
        run_checked("midrun", 1, 0, -1, 0, 1'b0, 1 + C_ROWS + 3 * 20 + 1);
        reset = 1'b1;
        @(posedge clk); #1;
        obs = observe();
        checks++;
        if (obs !== rec_t'('0)) begin
            errors++; $display("FAIL midrun_reset: got %h expected 0", obs);
        end
        reset = 1'b0;
        clear_model();
        run_checked("after_reset", 1, 0, -1, 0, 1'b0, -1);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.stall  = 1'b0;
        bus.num_ts = '0;
        test_reset();
        test_single();
        test_zero();
        test_multi();
        test_stall();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
